// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Misses stall the pipeline and move whole lines over a req/ack handshake with backing memory.
module dcache_controller #(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int SEL_W = OFF_W - 2;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BIT_W = SEL_W + 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [LINE_W-1:0]    data_r [NUM_LINES];

  logic [IDX_W-1:0]  miss_idx_r;
  logic [TAG_W-1:0]  miss_tag_r;
  logic [TAG_W-1:0]  victim_tag_r;
  logic [LINE_W-1:0] victim_line_r;

  logic [IDX_W-1:0]  req_idx_s;
  logic [TAG_W-1:0]  req_tag_s;
  logic [SEL_W-1:0]  word_sel_s;
  logic [BIT_W-1:0]  word_base_s;
  logic [LINE_W-1:0] cur_line_s;
  logic [31:0]       cur_word_s;
  logic              hit_s;
  logic              victim_dirty_s;
  logic              unused_addr_s;

  logic              stall_s;
  logic              mem_req_s;
  logic              mem_write_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [LINE_W-1:0] mem_data_s;
  logic [31:0]       cpu_data_s;
  logic              miss_s;
  logic              fill_s;
  logic              store_hit_s;

  // Accesses are word-only; the byte-lane bits carry no information.
  assign unused_addr_s  = ^cpu_addr_i[1:0];

  assign req_idx_s      = cpu_addr_i[OFF_W +: IDX_W];
  assign req_tag_s      = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign word_sel_s     = cpu_addr_i[OFF_W-1:2];
  assign word_base_s    = {word_sel_s, 5'd0};
  assign cur_line_s     = data_r[req_idx_s];
  assign cur_word_s     = cur_line_s[word_base_s +: 32];
  assign hit_s          = cpu_req_i & valid_r[req_idx_s] & (tag_r[req_idx_s] == req_tag_s);
  assign victim_dirty_s = valid_r[req_idx_s] & dirty_r[req_idx_s];

  // Next-state and output decode; outputs are combinational so hits cost no cycle.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    mem_addr_s  = '0;
    mem_data_s  = '0;
    cpu_data_s  = 32'd0;
    miss_s      = 1'b0;
    fill_s      = 1'b0;
    store_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit_s) begin
            if (cpu_write_i) begin
              store_hit_s = 1'b1;
            end else begin
              cpu_data_s = cur_word_s;
            end
          end else begin
            stall_s = 1'b1;
            miss_s  = 1'b1;
            if (victim_dirty_s) begin
              state_nxt_s = WRITEBACK;
            end else begin
              state_nxt_s = ALLOCATE;
            end
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        stall_s     = 1'b1;
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        mem_addr_s  = {victim_tag_r, miss_idx_r, {OFF_W{1'b0}}};
        mem_data_s  = victim_line_r;
        if (mem_ack_i) begin
          state_nxt_s = ALLOCATE;
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        stall_s    = 1'b1;
        mem_req_s  = 1'b1;
        mem_addr_s = {miss_tag_r, miss_idx_r, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          fill_s      = 1'b1;
          state_nxt_s = REFILL;
        end else begin
          state_nxt_s = ALLOCATE;
        end
      end
      REFILL: begin
        // One bubble so the replayed access sees the new line and req never runs back to back.
        stall_s     = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Reset must force the CPU-facing outputs low even while a miss is being decoded.
  assign cpu_data_o  = rst_i ? 32'd0 : cpu_data_s;
  assign cpu_stall_o = rst_i ? 1'b0  : stall_s;
  assign mem_req_o   = rst_i ? 1'b0  : mem_req_s;
  assign mem_write_o = rst_i ? 1'b0  : mem_write_s;
  assign mem_addr_o  = rst_i ? '0    : mem_addr_s;
  assign mem_data_o  = rst_i ? '0    : mem_data_s;

  // Controller state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Line status bits: a fill makes a line clean, a store hit makes it dirty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill_s) begin
      valid_r[miss_idx_r] <= 1'b1;
      dirty_r[miss_idx_r] <= 1'b0;
    end else if (store_hit_s) begin
      dirty_r[req_idx_s] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are qualified by valid_r so they need no reset.
  always_ff @(posedge clk_i) begin
    if (fill_s) begin
      tag_r[miss_idx_r]  <= miss_tag_r;
      data_r[miss_idx_r] <= mem_data_i;
    end else if (store_hit_s) begin
      data_r[req_idx_s][word_base_s +: 32] <= cpu_data_i;
    end
  end

  // Capture the missing address and its victim at the miss edge for the whole transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_idx_r    <= '0;
      miss_tag_r    <= '0;
      victim_tag_r  <= '0;
      victim_line_r <= '0;
    end else if (miss_s) begin
      miss_idx_r    <= req_idx_s;
      miss_tag_r    <= req_tag_s;
      victim_tag_r  <= tag_r[req_idx_s];
      victim_line_r <= cur_line_s;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a backing-memory model answers line requests and a
// scoreboard queue holds the load data and stall counts expected for each access.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [255:0] val;
  } exp_t;
  exp_t sb_q[$];

  logic [255:0] mem_model [logic [31:0]];

  dcache_controller dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cpu_req_i  (cpu_req_i),
    .cpu_write_i(cpu_write_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .cpu_stall_o(cpu_stall_o),
    .mem_req_o  (mem_req_o),
    .mem_write_o(mem_write_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Untouched memory line at address a holds word w = 0x1000 + (a>>5)*0x1000 + w.
  function automatic logic [255:0] model_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h1000 + (a >> 5) * 32'h1000 + 32'(w);
    return l;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, 256'(obs), 256'(exp));
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check(tag, 256'(obs), 256'(exp));
  endtask

  task automatic sb_pop(input logic [255:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_underflow observed=%0h expected=queued_entry", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  // One memory transaction: outputs held every cycle, ack pulsed dly cycles after entry.
  task automatic serve(input string name, input bit wr, input logic [31:0] a, input int dly,
                       input logic [255:0] wb_line, inout int stalls);
    string ph;
    if (wr) ph = "_wb"; else ph = "_al";
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      stalls += int'(cpu_stall_o);
      chk1({name, ph, "_req"}, mem_req_o, 1'b1);
      chk1({name, ph, "_write"}, mem_write_o, wr);
      chk32({name, ph, "_addr"}, mem_addr_o, a);
      if (wr) check({name, ph, "_line"}, mem_data_o, wb_line);
      if (c == dly) begin
        mem_ack_i = 1'b1;
        if (wr) mem_model[a] = mem_data_o;
        else mem_data_i = model_line(a);
      end
    end
  endtask

  task automatic access(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit miss, input bit wb,
                        input logic [31:0] wb_addr, input logic [255:0] wb_line,
                        input int wb_dly, input int al_dly, input logic [31:0] exp_data);
    int stalls;
    int exp_stalls;
    exp_stalls = !miss ? 0 : (wb ? wb_dly + al_dly + 4 : al_dly + 3);
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    if (!wr) sb_q.push_back('{tag: {name, "_data"}, val: 256'(exp_data)});
    sb_q.push_back('{tag: {name, "_stalls"}, val: 256'(exp_stalls)});
    #1;
    stalls = 0;
    if (miss) begin
      stalls += int'(cpu_stall_o);
      chk1({name, "_missreq"}, mem_req_o, 1'b0);
      if (wb) serve(name, 1'b1, wb_addr, wb_dly, wb_line, stalls);
      serve(name, 1'b0, {addr[31:5], 5'd0}, al_dly, 256'd0, stalls);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      stalls += int'(cpu_stall_o);
      chk1({name, "_refill_req"}, mem_req_o, 1'b0);
      @(negedge clk_i);
      #1;
    end
    chk1({name, "_done_stall"}, cpu_stall_o, 1'b0);
    chk1({name, "_done_req"}, mem_req_o, 1'b0);
    if (!wr) sb_pop(256'(cpu_data_o));
    sb_pop(256'(stalls));
  endtask

  initial begin
    logic [255:0] dirty_line;
    rst_i       = 1'b1;
    cpu_req_i   = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i  = 32'h0000_0004;
    cpu_data_i  = 32'd0;
    mem_data_i  = '0;
    mem_ack_i   = 1'b0;
    #2;
    chk1("rst_stall", cpu_stall_o, 1'b0);
    chk1("rst_req", mem_req_o, 1'b0);
    chk1("rst_write", mem_write_o, 1'b0);
    chk32("rst_addr", mem_addr_o, 32'd0);
    check("rst_mdata", mem_data_o, 256'd0);
    chk32("rst_cdata", cpu_data_o, 32'd0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    chk1("idle_stall", cpu_stall_o, 1'b0);

    // Cold load miss, ack three cycles into ALLOCATE, then hits on the same line.
    access("cold", 1'b0, 32'h0000_0004, 32'd0, 1'b1, 1'b0, 32'd0, 256'd0, 0, 3, 32'h0000_1001);
    access("hit8", 1'b0, 32'h0000_0008, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0, 0, 0, 32'h0000_1002);
    access("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 256'd0, 0, 0, 32'd0);
    access("ld10", 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0, 0, 0, 32'hDEAD_BEEF);

    // Conflict on index 0 evicts the dirty line, then reloading the old line needs no write-back.
    dirty_line = model_line(32'h0000_0000);
    dirty_line[159:128] = 32'hDEAD_BEEF;
    access("evict", 1'b0, 32'h0000_0200, 32'd0, 1'b1, 1'b1, 32'h0000_0000, dirty_line, 2, 1,
           32'h0001_1000);
    access("reload", 1'b0, 32'h0000_0010, 32'd0, 1'b1, 1'b0, 32'd0, 256'd0, 0, 0, 32'hDEAD_BEEF);

    // Slow memory, then a stray ack in IDLE must be ignored.
    access("slow", 1'b0, 32'h0000_0404, 32'd0, 1'b1, 1'b0, 32'd0, 256'd0, 0, 10, 32'h0002_1001);
    @(negedge clk_i);
    cpu_req_i  = 1'b0;
    mem_ack_i  = 1'b1;
    mem_data_i = '1;
    #1;
    chk1("spur_stall", cpu_stall_o, 1'b0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk1("spur_req", mem_req_o, 1'b0);
    chk1("spur_stall2", cpu_stall_o, 1'b0);
    access("slowhit", 1'b0, 32'h0000_0404, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0, 0, 0, 32'h0002_1001);

    // Store miss allocates the line and merges the store word.
    access("stmiss", 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 1'b1, 1'b0, 32'd0, 256'd0, 0, 0, 32'd0);
    access("ld24", 1'b0, 32'h0000_0024, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0, 0, 0, 32'hCAFE_F00D);
    access("ld20", 1'b0, 32'h0000_0020, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0, 0, 0, 32'h0000_2000);

    // Reset while ALLOCATE is requesting.
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i  = 32'h0000_0044;
    #1;
    chk1("rmid_miss_stall", cpu_stall_o, 1'b1);
    @(negedge clk_i);
    #1;
    chk1("rmid_req_before", mem_req_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk1("rmid_req", mem_req_o, 1'b0);
    chk1("rmid_stall", cpu_stall_o, 1'b0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    cpu_req_i = 1'b0;
    access("postrst", 1'b0, 32'h0000_0004, 32'd0, 1'b1, 1'b0, 32'd0, 256'd0, 0, 0, 32'h0000_1001);

    @(negedge clk_i);
    cpu_req_i = 1'b0;
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller in the MEM stage.
- Replaces the direct Data_Memory hookup: it takes the EX_MEM address, data and MemRead/MemWrite, and returns load data to the MEM_WB path.
- On a miss it freezes the pipeline through cpu_stall_o and moves whole 32-byte lines over a req/ack handshake with backing memory.

Parameters:
- NUM_LINES, 16, number of cache lines. The index is log2(NUM_LINES) bits wide.
- LINE_W, 256, line width in bits (32 bytes, 8 words).
- ADDR_W, 32, byte-address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cpu_req_i  in  1  access valid (MemRead | MemWrite from EX_MEM).
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address (ALU result).
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB while high.
- mem_req_o  out  1  memory request.
- mem_write_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address; bits [4:0] are always 0.
- mem_data_o  out  256  victim line on write-back.
- mem_data_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split (default parameters):
  - offset: bits [4:0]; word select is [4:2].
  - index: [8:5].
  - tag: [31:9], 23 bits.
- Storage per line: valid, dirty, tag, 256-bit data.
- Word w of a line occupies bits [32w+31 : 32w].
- Reset (asynchronous, immediate):
  - All valid and dirty bits clear; state = IDLE.
  - cpu_data_o = 0, cpu_stall_o = 0, mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - Reset during WRITEBACK or ALLOCATE abandons the transfer, and mem_req_o drops in the same instant.
- hit = cpu_req_i & valid[idx] & (tag[idx] == addr tag).
- States: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE, cpu_req_i = 0:
  - No state change; stall 0; cpu_data_o = 0.
- IDLE, load hit:
  - cpu_data_o = selected word, combinationally in the same cycle; stall 0.
- IDLE, store hit:
  - The selected word is written at the clock edge and dirty is set; stall 0.
- IDLE, miss:
  - cpu_stall_o = 1 combinationally in the same cycle.
  - Next state is WRITEBACK if the victim is valid & dirty, otherwise ALLOCATE.
  - The victim tag and line are latched at this edge.
- WRITEBACK:
  - mem_req_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, idx, 5'b0}; mem_data_o = victim line.
  - Outputs are held stable until mem_ack_i, then the controller goes to ALLOCATE.
- ALLOCATE:
  - mem_req_o = 1, mem_write_o = 0, mem_addr_o = {cpu tag, idx, 5'b0}.
  - On mem_ack_i: line ← mem_data_i, tag updated, valid = 1, dirty = 0; go to REFILL.
- REFILL:
  - mem_req_o = 0; stall still 1; go to IDLE.
  - The request now hits in IDLE: a load returns data, a store merges and sets dirty, and stall falls that cycle.
- Stall timing:
  - cpu_stall_o = 1 in every cycle spent in WRITEBACK, ALLOCATE and REFILL, and in the IDLE miss cycle.
  - Clean miss with ack arriving k cycles after ALLOCATE entry: 3 + k stall cycles.
- CPU contract: cpu_* inputs are held stable while cpu_stall_o = 1. The controller does not re-sample them mid-miss.
- mem_ack_i is ignored in IDLE and REFILL.
- mem_req_o deasserts in the cycle after the ack edge; it is never asserted back to back across REFILL.
- Sub-word accesses: none. cpu_addr_i[1:0] is ignored (word accesses only).

Test Plan:
- Cold load miss:
  - Stimulus: reset, then load 0x00000004; memory acks 3 cycles after request with a line whose word w = 0x1000 + w.
  - Required: mem_req_o = 1, mem_write_o = 0, mem_addr_o = 0x00000000; stall high for 6 cycles; then cpu_data_o = 0x00001001 with stall 0.
- Load hit:
  - Stimulus: load 0x00000008 right after the cold miss.
  - Required: cpu_data_o = 0x00001002 in the same cycle; stall 0; mem_req_o never asserts.
- Store hit:
  - Stimulus: store 0xDEADBEEF to 0x00000010, then load 0x00000010.
  - Required: no stall on either access; the load returns 0xDEADBEEF; the line becomes dirty.
- Conflict eviction:
  - Stimulus: load 0x00000200 (index 0, new tag).
  - Required: WRITEBACK to 0x00000000 with mem_data_o[159:128] = 0xDEADBEEF, followed by ALLOCATE to 0x00000200.
  - Required: loading 0x00000010 afterwards misses again with a clean victim, so there is no WRITEBACK.
- Slow memory:
  - Stimulus: ack delayed 10 cycles during ALLOCATE.
  - Required: mem_req_o, mem_addr_o and cpu_stall_o held stable for all 10 cycles; a spurious ack pulse in IDLE causes no state change.
- Reset mid-ALLOCATE:
  - Stimulus: assert rst_i while mem_req_o = 1.
  - Required: mem_req_o and cpu_stall_o go to 0 immediately; a later load of 0x00000004 misses again and requests 0x00000000.
